// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared FPU definitions: opcodes, flag bit positions and the issue controller state encoding.
package fpu_issue_ctrl_pkg;

  localparam int OPCODE_W = 2;

  localparam logic [OPCODE_W-1:0] OP_ADD = 2'b00;
  localparam logic [OPCODE_W-1:0] OP_SUB = 2'b01;
  localparam logic [OPCODE_W-1:0] OP_DIV = 2'b10;
  localparam logic [OPCODE_W-1:0] OP_MUL = 2'b11;

  localparam int FLAG_W   = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_DBZ = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic ovf, input logic unf, input logic dbz);
    logic [FLAG_W-1:0] f;
    f           = '0;
    f[FLAG_OVF] = ovf;
    f[FLAG_UNF] = unf;
    f[FLAG_DBZ] = dbz;
    return f;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and the FPU issue controller (slave).
interface fpu_issue_ctrl_if
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPCODE_W = 2
);

  logic                req_valid;
  logic                req_ready;
  logic [DATA_W-1:0]   req_a;
  logic [DATA_W-1:0]   req_b;
  logic [OPCODE_W-1:0] req_op;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic [FLAG_W-1:0]   rsp_flags;
  logic                rsp_timeout;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flags, rsp_timeout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flags, rsp_timeout
  );

endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issues one FPU operation at a time; response valid one cycle after fpu_done (or after TIMEOUT wait cycles).
// Single outstanding op: req_ready only in IDLE; response held in RESP until rsp_ready.
module fpu_issue_ctrl #(
  parameter int DATA_W   = 32,
  parameter int OPCODE_W = fpu_issue_ctrl_pkg::OPCODE_W,
  parameter int TIMEOUT  = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  fpu_issue_ctrl_if.slave                       bus,
  output logic                                  fpu_run,
  output logic                                  fpu_running,
  output logic [DATA_W-1:0]                     fpu_in0,
  output logic [DATA_W-1:0]                     fpu_in1,
  output logic [OPCODE_W-1:0]                   fpu_op,
  input  logic [DATA_W-1:0]                     fpu_out0,
  input  logic                                  fpu_done,
  input  logic                                  fpu_overflow,
  input  logic                                  fpu_underflow,
  input  logic                                  fpu_div_by_zero,
  input  logic                                  flag_clr,
  output logic [fpu_issue_ctrl_pkg::FLAG_W-1:0] sticky_flags,
  output logic                                  busy
);
  import fpu_issue_ctrl_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [FLAG_W-1:0] acc;
  logic [FLAG_W-1:0] cur_flags;

  assign cur_flags = pack_flags(fpu_overflow, fpu_underflow, fpu_div_by_zero);

  // fpu_in0/fpu_in1/fpu_op are the operand registers themselves, so they only change on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      bus.req_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_flags   <= '0;
      bus.rsp_timeout <= 1'b0;
      fpu_run         <= 1'b0;
      fpu_running     <= 1'b0;
      fpu_in0         <= '0;
      fpu_in1         <= '0;
      fpu_op          <= '0;
      sticky_flags    <= '0;
      busy            <= 1'b0;
      cnt             <= '0;
      acc             <= '0;
    end else begin
      if (flag_clr) sticky_flags <= '0;
      unique case (state)
        ST_IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            fpu_in0       <= bus.req_a;
            fpu_in1       <= bus.req_b;
            fpu_op        <= bus.req_op;
            bus.req_ready <= 1'b0;
            fpu_run       <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          fpu_run     <= 1'b0;
          fpu_running <= 1'b1;
          cnt         <= '0;
          acc         <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // done is checked first so it wins over a coincident timeout
          if (fpu_done) begin
            bus.rsp_data    <= fpu_out0;
            bus.rsp_flags   <= acc | cur_flags;
            bus.rsp_timeout <= 1'b0;
            sticky_flags    <= (flag_clr ? '0 : sticky_flags) | acc | cur_flags;
            bus.rsp_valid   <= 1'b1;
            fpu_running     <= 1'b0;
            state           <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.rsp_data    <= '0;
            bus.rsp_flags   <= '0;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            fpu_running     <= 1'b0;
            state           <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc | cur_flags;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid   <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.req_ready   <= 1'b1;
            busy            <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a behavioural FPU stub (sum/difference after stub_lat cycles).
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  localparam int DW  = 32;
  localparam int OW  = 2;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fpu_run, fpu_running, busy;
  logic          flag_clr = 1'b0;
  logic [DW-1:0] fpu_in0, fpu_in1;
  logic [DW-1:0] fpu_out0 = '0;
  logic [OW-1:0] fpu_op;
  logic          fpu_done = 1'b0, fpu_overflow = 1'b0, fpu_underflow = 1'b0, fpu_div_by_zero = 1'b0;
  logic [2:0]    sticky_flags;

  int errors = 0;
  int checks = 0;

  int            stub_lat = 5, dbz_at = 0, ovf_at = 0, stub_cnt = 0, run_cnt = 0;
  bit            stub_act = 1'b0;
  logic [DW-1:0] stub_res = '0;

  fpu_issue_ctrl_if #(.DATA_W(DW), .OPCODE_W(OW)) bus ();

  fpu_issue_ctrl #(.DATA_W(DW), .OPCODE_W(OW), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .fpu_run         (fpu_run),
    .fpu_running     (fpu_running),
    .fpu_in0         (fpu_in0),
    .fpu_in1         (fpu_in1),
    .fpu_op          (fpu_op),
    .fpu_out0        (fpu_out0),
    .fpu_done        (fpu_done),
    .fpu_overflow    (fpu_overflow),
    .fpu_underflow   (fpu_underflow),
    .fpu_div_by_zero (fpu_div_by_zero),
    .flag_clr        (flag_clr),
    .sticky_flags    (sticky_flags),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // FPU stub: stub_cnt is 0 in the fpu_run cycle and k in the k-th WAIT cycle.
  always @(negedge clk) begin
    if (fpu_run) begin
      stub_act = 1'b1;
      stub_cnt = 0;
      run_cnt++;
      stub_res = (fpu_op == OP_SUB) ? fpu_in0 - fpu_in1 : fpu_in0 + fpu_in1;
    end else if (stub_act) begin
      stub_cnt++;
    end
    fpu_done        = stub_act && stub_lat != 0 && stub_cnt == stub_lat;
    fpu_out0        = fpu_done ? stub_res : '0;
    fpu_div_by_zero = stub_act && dbz_at != 0 && stub_cnt == dbz_at;
    fpu_overflow    = stub_act && ovf_at != 0 && stub_cnt == ovf_at;
    fpu_underflow   = 1'b0;
    if (fpu_done) stub_act = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns in the fpu_run cycle (cycle 1).
  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Advances until rsp_valid; n is the cycle index (acceptance edge ends cycle 0).
  task automatic wait_rsp(input int start, output int n);
    n = start;
    while (!bus.rsp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got=%0b exp=0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%0b exp=0", bus.rsp_valid); end
    checks++; if (busy !== 1'b0 || fpu_run !== 1'b0 || fpu_running !== 1'b0) begin errors++; $display("FAIL rst_ctrl got=%0b%0b%0b exp=000", busy, fpu_run, fpu_running); end
    checks++; if (bus.rsp_data !== '0 || fpu_in0 !== '0 || sticky_flags !== 3'b000) begin errors++; $display("FAIL rst_regs data=%0h in0=%0h sticky=%0b exp=0", bus.rsp_data, fpu_in0, sticky_flags); end
    rst = 1'b0;
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%0b exp=1", bus.req_ready); end
  endtask

  task automatic test_basic();
    int n;
    stub_lat = 5;
    issue(32'd3, 32'd4, OP_ADD);
    checks++; if (fpu_run !== 1'b1) begin errors++; $display("FAIL basic_run_c1 got=%0b exp=1", fpu_run); end
    checks++; if (fpu_in0 !== 32'd3 || fpu_in1 !== 32'd4 || fpu_op !== OP_ADD) begin errors++; $display("FAIL basic_operands got=%0h/%0h/%0h exp=3/4/0", fpu_in0, fpu_in1, fpu_op); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL basic_req_ready_busy got=%0b exp=0", bus.req_ready); end
    tick();
    checks++; if (fpu_run !== 1'b0 || fpu_running !== 1'b1) begin errors++; $display("FAIL basic_wait run=%0b running=%0b exp=0/1", fpu_run, fpu_running); end
    wait_rsp(2, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL basic_latency got=%0d exp=7", n); end
    checks++; if (bus.rsp_data !== 32'd7) begin errors++; $display("FAIL basic_data got=%0h exp=7", bus.rsp_data); end
    checks++; if (bus.rsp_flags !== 3'b000 || bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL basic_flags got=%0b/%0b exp=000/0", bus.rsp_flags, bus.rsp_timeout); end
    checks++; if (fpu_in0 !== 32'd3 || busy !== 1'b1) begin errors++; $display("FAIL basic_resp_hold in0=%0h busy=%0b exp=3/1", fpu_in0, busy); end
    handshake();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle got=%0b%0b%0b exp=010", bus.rsp_valid, bus.req_ready, busy); end
  endtask

  task automatic test_backpressure();
    int n;
    issue(32'd10, 32'd5, OP_SUB);
    wait_rsp(1, n);
    checks++; if (bus.rsp_data !== 32'd5) begin errors++; $display("FAIL bp_data got=%0h exp=5", bus.rsp_data); end
    bus.req_valid = 1'b1;
    bus.req_a     = 32'd1;
    bus.req_b     = 32'd1;
    bus.req_op    = OP_ADD;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd5) begin errors++; $display("FAIL bp_hold cyc=%0d valid=%0b data=%0h exp=1/5", i, bus.rsp_valid, bus.rsp_data); end
      checks++; if (bus.req_ready !== 1'b0 || fpu_run !== 1'b0) begin errors++; $display("FAIL bp_no_accept cyc=%0d ready=%0b run=%0b exp=0/0", i, bus.req_ready, fpu_run); end
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || fpu_run !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_after_hs got=%0b%0b%0b exp=001", bus.rsp_valid, fpu_run, bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checks++; if (fpu_run !== 1'b1 || fpu_in0 !== 32'd1) begin errors++; $display("FAIL bp_next_accept run=%0b in0=%0h exp=1/1", fpu_run, fpu_in0); end
    wait_rsp(1, n);
    checks++; if (bus.rsp_data !== 32'd2) begin errors++; $display("FAIL bp_next_data got=%0h exp=2", bus.rsp_data); end
    handshake();
  endtask

  task automatic test_flags();
    int n;
    dbz_at = 2;
    issue(32'd1, 32'd2, OP_ADD);
    wait_rsp(1, n);
    checks++; if (bus.rsp_flags !== 3'b001 || bus.rsp_data !== 32'd3) begin errors++; $display("FAIL flags_dbz flags=%0b data=%0h exp=001/3", bus.rsp_flags, bus.rsp_data); end
    checks++; if (sticky_flags !== 3'b001) begin errors++; $display("FAIL flags_sticky_dbz got=%0b exp=001", sticky_flags); end
    handshake();
    dbz_at = 0;
    ovf_at = 1;
    issue(32'd5, 32'd5, OP_ADD);
    repeat (5) tick();
    checks++; if (sticky_flags !== 3'b001 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL flags_pre_resp sticky=%0b valid=%0b exp=001/0", sticky_flags, bus.rsp_valid); end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_flags !== 3'b100) begin errors++; $display("FAIL flags_ovf valid=%0b flags=%0b exp=1/100", bus.rsp_valid, bus.rsp_flags); end
    checks++; if (sticky_flags !== 3'b100) begin errors++; $display("FAIL flags_set_wins got=%0b exp=100", sticky_flags); end
    handshake();
    ovf_at = 0;
  endtask

  task automatic test_timeout();
    int n;
    stub_lat = 0;
    issue(32'd9, 32'd9, OP_ADD);
    wait_rsp(1, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL tmo_latency got=%0d exp=10", n); end
    checks++; if (bus.rsp_timeout !== 1'b1 || bus.rsp_data !== '0 || bus.rsp_flags !== 3'b000) begin errors++; $display("FAIL tmo_resp tmo=%0b data=%0h flags=%0b exp=1/0/000", bus.rsp_timeout, bus.rsp_data, bus.rsp_flags); end
    checks++; if (sticky_flags !== 3'b100) begin errors++; $display("FAIL tmo_sticky got=%0b exp=100", sticky_flags); end
    handshake();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++; if (sticky_flags !== 3'b000) begin errors++; $display("FAIL clr_only got=%0b exp=000", sticky_flags); end
  endtask

  task automatic test_done_vs_timeout();
    int n;
    stub_lat = 8;
    issue(32'd20, 32'd22, OP_ADD);
    wait_rsp(1, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL race_latency got=%0d exp=10", n); end
    checks++; if (bus.rsp_timeout !== 1'b0 || bus.rsp_data !== 32'd42) begin errors++; $display("FAIL race_done_wins tmo=%0b data=%0h exp=0/2a", bus.rsp_timeout, bus.rsp_data); end
    handshake();
  endtask

  task automatic test_reset_mid();
    bit seen;
    stub_lat = 5;
    issue(32'd6, 32'd6, OP_ADD);
    repeat (3) tick();
    checks++; if (fpu_running !== 1'b1) begin errors++; $display("FAIL rmid_in_wait got=%0b exp=1", fpu_running); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || fpu_running !== 1'b0 || bus.rsp_valid !== 1'b0 || fpu_in0 !== '0) begin errors++; $display("FAIL rmid_abort busy=%0b run=%0b valid=%0b in0=%0h exp=0/0/0/0", busy, fpu_running, bus.rsp_valid, fpu_in0); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp got=%0b exp=0", seen); end
    checks++; if (bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.rsp_data !== '0) begin errors++; $display("FAIL rmid_idle ready=%0b busy=%0b data=%0h exp=1/0/0", bus.req_ready, busy, bus.rsp_data); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] va[4], vb[4], vexp[4];
    logic [OW-1:0] vop[4];
    int acc_cyc[4];
    int sent, got, cyc, runs0;
    bit acc;
    va   = '{32'd3, 32'd100, 32'hFFFF_FFFF, 32'd7};
    vb   = '{32'd4, 32'd1, 32'd1, 32'd9};
    vop  = '{OP_ADD, OP_SUB, OP_ADD, OP_SUB};
    vexp = '{32'd7, 32'd99, 32'd0, 32'hFFFF_FFFE};
    acc_cyc = '{0, 0, 0, 0};
    sent = 0; got = 0; cyc = 0;
    runs0 = run_cnt;
    stub_lat = 5;
    bus.rsp_ready = 1'b1;
    while (got < 4 && cyc < 200) begin
      bus.req_valid = (sent < 4);
      if (sent < 4) begin
        bus.req_a  = va[sent];
        bus.req_b  = vb[sent];
        bus.req_op = vop[sent];
      end
      acc = bus.req_valid && bus.req_ready;
      if (bus.rsp_valid) begin
        checks++; if (bus.rsp_data !== vexp[got]) begin errors++; $display("FAIL b2b_data idx=%0d got=%0h exp=%0h", got, bus.rsp_data, vexp[got]); end
        got++;
      end
      tick();
      if (acc) begin
        acc_cyc[sent] = cyc;
        sent++;
      end
      cyc++;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checks++; if (got !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", got); end
    checks++; if (run_cnt - runs0 !== 4) begin errors++; $display("FAIL b2b_runs got=%0d exp=4", run_cnt - runs0); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 8) begin errors++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=8", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flags();
    test_timeout();
    test_done_vs_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width.
REQ-002 SHALL have parameter OPCODE_W, default 2: FPU opcode width (00 add, 01 sub, 10 div, 11 mul).
REQ-003 SHALL have parameter TIMEOUT, default 64: maximum FPU cycles before abort (range 2..65535).
REQ-004 SHALL have ports: clk input 1, clock; rst input 1, reset, synchronous, active-high.
REQ-005 SHALL have ports: req_valid input 1; req_ready output 1; req_a input DATA_W; req_b input DATA_W; req_op input OPCODE_W.
REQ-006 SHALL have ports: rsp_valid output 1; rsp_ready input 1; rsp_data output DATA_W; rsp_flags output 3 {ovf,unf,dbz}; rsp_timeout output 1.
REQ-007 SHALL have ports: fpu_run output 1; fpu_running output 1; fpu_in0 output DATA_W; fpu_in1 output DATA_W; fpu_op output OPCODE_W.
REQ-008 SHALL have ports: fpu_out0 input DATA_W; fpu_done input 1; fpu_overflow input 1; fpu_underflow input 1; fpu_div_by_zero input 1.
REQ-009 SHALL have ports: flag_clr input 1, clears sticky flags; sticky_flags output 3 {ovf,unf,dbz}; busy output 1, high in any state except IDLE.

Function
REQ-010 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP.
REQ-011 In IDLE: req_ready=1; on req_valid&req_ready, register req_a/req_b/req_op into operand registers and go to ISSUE.
REQ-012 fpu_in0/fpu_in1/fpu_op SHALL be driven only from the operand registers and held stable from ISSUE through RESP.
REQ-013 In ISSUE: fpu_run=1 for exactly one cycle; the per-op flag accumulator and timeout counter are cleared; next state is WAIT.
REQ-014 In WAIT: fpu_running=1; the counter increments each cycle; the flag accumulator ORs in {fpu_overflow,fpu_underflow,fpu_div_by_zero} each cycle.
REQ-015 In WAIT with fpu_done=1: register fpu_out0 into rsp_data and go to RESP; the flags sampled on that same cycle are included.
REQ-016 In WAIT with counter==TIMEOUT-1 and fpu_done=0: set rsp_data=0, set rsp_timeout=1, and go to RESP.
REQ-017 If fpu_done and the timeout condition occur on the same cycle, done SHALL win (rsp_timeout=0).
REQ-018 fpu_done outside WAIT SHALL be ignored.
REQ-019 In RESP: rsp_valid=1; rsp_data, rsp_flags and rsp_timeout are held stable until rsp_ready; on rsp_valid&rsp_ready go to IDLE.
REQ-020 req_ready SHALL be 0 outside IDLE, allowing one outstanding operation only.
REQ-021 Latency: a request accepted at edge N gives fpu_run high in cycle N+1; rsp_valid rises one cycle after the fpu_done cycle.
REQ-022 sticky_flags SHALL be updated by OR with rsp_flags on entry to RESP; flag_clr clears them.
REQ-023 When flag_clr and a sticky update coincide, sticky_flags SHALL equal the new rsp_flags (set wins).
REQ-024 A timeout SHALL not set any flag bit.
REQ-025 Back-to-back throughput: when rsp_ready is held high, the next request is accepted on the cycle after the RESP handshake.

Reset
REQ-026 On rst: state=IDLE; req_ready=0 during reset then 1; rsp_valid, fpu_run, fpu_running, busy, rsp_timeout=0; rsp_data, rsp_flags, sticky_flags, operand registers and counter=0.
REQ-027 rst mid-operation SHALL abort immediately with no response emitted; a later fpu_done SHALL be ignored.

Structure
REQ-028 Opcode encodings (OP_ADD, OP_SUB, OP_DIV, OP_MUL), OPCODE_W and flag bit indices SHALL reside in the shared defs package used by the FPU.
REQ-029 The block SHALL be flat; the counter width SHALL be $clog2(TIMEOUT)+1, and no sub-module is required.

Verification
REQ-030 Stub FPU with latency 5 returning in0+in1: request a=3, b=4, op=00 -> fpu_run in cycle 1, rsp_valid in cycle 7, rsp_data=7, flags=000.
REQ-031 rsp_ready held low for 10 cycles -> rsp_valid and rsp_data stay stable; req_ready=0 throughout; the next request is accepted only after the handshake.
REQ-032 Stub pulses fpu_div_by_zero in WAIT cycle 2 and done in cycle 5 -> rsp_flags=001 and sticky_flags=001; flag_clr on the next RESP entry with ovf set -> sticky_flags=100.
REQ-033 Stub never asserts done, TIMEOUT=8 -> rsp_valid after 8 WAIT cycles, rsp_timeout=1, rsp_data=0, sticky_flags unchanged.
REQ-034 rst asserted in WAIT cycle 3, then done pulses -> no rsp_valid; state is IDLE and req_ready=1 after reset.
REQ-035 Four back-to-back requests with rsp_ready=1 -> four in-order responses, each rsp_data matching its operands, and one fpu_run per request.
